// File: rtl/dsm_mix_mod.sv
// Zero-order-hold interpolator, 3-level LO mixer and second-order 3-level
// delta-sigma modulator driving a 2-bit pwm symbol stream.
module dsm_mix_mod #(
  parameter int W   = 20,
  parameter int OSR = 4,
  parameter int AW  = W + 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   lo_mode,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clr_flags,
  output logic [1:0]   pwm,
  output logic         underrun,
  output logic         overload
);

  localparam int CW = $clog2(OSR);
  localparam int SW = AW + 2;
  localparam logic [CW-1:0] OSR_LAST = CW'(OSR - 1);

  localparam logic [1:0] LO_ZERO = 2'b00;
  localparam logic [1:0] LO_POS  = 2'b01;
  localparam logic [1:0] LO_NEG  = 2'b11;

  localparam logic signed [AW-1:0] I_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] I_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX = {2'b00, I_MAX};
  localparam logic signed [SW-1:0] S_MIN = {2'b11, I_MIN};
  localparam logic signed [SW-1:0] FB_ONE = {{(SW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] THR_P = {{(AW-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
  localparam logic signed [AW-1:0] THR_N = -THR_P;

  logic [CW-1:0]          osr_cnt_q;
  logic [1:0]             lo_cnt_q;
  logic [1:0]             mode_q;
  logic signed [W-1:0]    hold_q;
  logic signed [AW-1:0]   i1_q, i2_q, i1_d, i2_d;
  logic [1:0]             pwm_q, pwm_d;
  logic                   underrun_q, overload_q;
  logic [1:0]             lo_val;
  logic signed [W:0]      hold_ext, mix;
  logic signed [SW-1:0]   fb, sum1, sum2;
  logic                   clamp1, clamp2;

  // Gated by reset so in_ready drops together with the async reset.
  assign in_ready = reset && enable && (osr_cnt_q == OSR_LAST);

  always_comb begin
    lo_val = LO_ZERO;
    case (mode_q)
      2'd0:    lo_val = LO_POS;
      2'd1:    lo_val = lo_cnt_q[0] ? LO_NEG : LO_POS;
      2'd2:    lo_val = lo_cnt_q[0] ? (lo_cnt_q[1] ? LO_NEG : LO_POS) : LO_ZERO;
      default: lo_val = LO_ZERO;
    endcase
  end

  // One extra bit so negating the most negative sample stays exact.
  assign hold_ext = {hold_q[W-1], hold_q};

  always_comb begin
    mix = '0;
    case (lo_val)
      LO_POS:  mix = hold_ext;
      LO_NEG:  mix = -hold_ext;
      default: mix = '0;
    endcase
  end

  always_comb begin
    fb = '0;
    case (pwm_q)
      2'b01:   fb = FB_ONE;
      2'b10:   fb = -FB_ONE;
      default: fb = '0;
    endcase
  end

  assign sum1 = {{2{i1_q[AW-1]}}, i1_q} + {{(SW-W-1){mix[W]}}, mix} - fb;
  assign sum2 = {{2{i2_q[AW-1]}}, i2_q} + {{2{i1_q[AW-1]}}, i1_q} - fb;

  always_comb begin
    clamp1 = 1'b0;
    i1_d   = sum1[AW-1:0];
    if (sum1 > S_MAX) begin
      i1_d   = I_MAX;
      clamp1 = 1'b1;
    end else if (sum1 < S_MIN) begin
      i1_d   = I_MIN;
      clamp1 = 1'b1;
    end
  end

  always_comb begin
    clamp2 = 1'b0;
    i2_d   = sum2[AW-1:0];
    if (sum2 > S_MAX) begin
      i2_d   = I_MAX;
      clamp2 = 1'b1;
    end else if (sum2 < S_MIN) begin
      i2_d   = I_MIN;
      clamp2 = 1'b1;
    end
  end

  always_comb begin
    pwm_d = 2'b00;
    if (i2_q >= THR_P)      pwm_d = 2'b01;
    else if (i2_q <= THR_N) pwm_d = 2'b10;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      osr_cnt_q  <= OSR_LAST;
      lo_cnt_q   <= 2'd0;
      mode_q     <= 2'd0;
      hold_q     <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      pwm_q      <= 2'b00;
      underrun_q <= 1'b0;
      overload_q <= 1'b0;
    end else if (!enable) begin
      // Flush everything but the sticky flags; the LO mode tracks the input.
      osr_cnt_q <= OSR_LAST;
      lo_cnt_q  <= 2'd0;
      mode_q    <= lo_mode;
      hold_q    <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      pwm_q     <= 2'b00;
    end else begin
      osr_cnt_q <= (osr_cnt_q == OSR_LAST) ? '0 : osr_cnt_q + CW'(1);
      lo_cnt_q  <= lo_cnt_q + 2'd1;
      if (lo_cnt_q == 2'd3) mode_q <= lo_mode;
      if (in_ready) hold_q <= in_valid ? in_data : '0;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      pwm_q      <= pwm_d;
      underrun_q <= (in_ready && !in_valid) || (underrun_q && !clr_flags);
      overload_q <= clamp1 || clamp2 || (overload_q && !clr_flags);
    end
  end

  assign pwm      = pwm_q;
  assign underrun = underrun_q;
  assign overload = overload_q;

endmodule

// File: tb/tb_dsm_mix_mod.sv
// Directed, table-driven bench for dsm_mix_mod (W=20, OSR=4); expected pwm
// sequences are hand-derived from the integrator/quantiser equations.
module tb_dsm_mix_mod;

  localparam int W = 20;
  localparam int OSR = 4;
  localparam int U = 262144;    // 2^18
  localparam int V = -524288;   // -2^19
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   lo_mode = 2'd0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         clr_flags = 1'b0;
  logic [1:0]   pwm;
  logic         underrun;
  logic         overload;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dsm_mix_mod #(.W(W), .OSR(OSR), .AW(W + 4)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .lo_mode  (lo_mode),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clr_flags(clr_flags),
    .pwm      (pwm),
    .underrun (underrun),
    .overload (overload)
  );

  typedef struct {
    logic       restart;
    logic       en;
    logic [1:0] mode;
    int         data;
    logic       valid;
    logic       clr;
    logic       exp_ready;
    logic [1:0] exp_pwm;
    logic       exp_under;
    logic       exp_over;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, input logic en, input logic [1:0] md, input int dt,
                     input logic vl, input logic cl, input logic rdy, input logic [1:0] pw,
                     input logic ur, input logic ov);
    vec_t v;
    v.restart = rs; v.en = en; v.mode = md; v.data = dt; v.valid = vl; v.clr = cl;
    v.exp_ready = rdy; v.exp_pwm = pw; v.exp_under = ur; v.exp_over = ov;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Reset, then one disabled edge so mode_q picks up the segment's LO mode.
  task automatic restart(input logic [1:0] mode);
    @(negedge clock);
    reset = 1'b0; enable = 1'b0; lo_mode = mode;
    in_valid = 1'b0; in_data = '0; clr_flags = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // mode 0, DC +2^18: e0..e17, then a one-cycle enable drop and restart
    add(1,1,0,U,1,0, 0,Z,0,0); add(0,1,0,U,1,0, 0,Z,0,0); add(0,1,0,U,1,0, 0,Z,0,0);
    add(0,1,0,U,1,0, 1,P,0,0); add(0,1,0,U,1,0, 0,P,0,0); add(0,1,0,U,1,0, 0,P,0,0);
    add(0,1,0,U,1,0, 0,P,0,0); add(0,1,0,U,1,0, 1,P,0,0); add(0,1,0,U,1,0, 0,P,0,0);
    add(0,1,0,U,1,0, 0,N,0,0); add(0,1,0,U,1,0, 0,N,0,0); add(0,1,0,U,1,0, 1,N,0,0);
    add(0,1,0,U,1,0, 0,N,0,0); add(0,1,0,U,1,0, 0,Z,0,0); add(0,1,0,U,1,0, 0,P,0,0);
    add(0,1,0,U,1,0, 1,P,0,0); add(0,1,0,U,1,0, 0,P,0,1); add(0,1,0,U,1,0, 0,P,0,1);
    add(0,0,0,U,1,0, 0,Z,0,1);
    add(0,1,0,U,1,0, 0,Z,0,1); add(0,1,0,U,1,0, 0,Z,0,1); add(0,1,0,U,1,0, 0,Z,0,1);
    add(0,1,0,U,1,0, 1,P,0,1);
    // mute, then mode 0 written at lo_cnt=1: mixer only sees it from e4
    add(1,1,3,U,1,0, 0,Z,0,0); add(0,1,0,U,1,0, 0,Z,0,0); add(0,1,0,U,1,0, 0,Z,0,0);
    add(0,1,0,U,1,0, 1,Z,0,0); add(0,1,0,U,1,0, 0,Z,0,0); add(0,1,0,U,1,0, 0,Z,0,0);
    add(0,1,0,U,1,0, 0,P,0,0); add(0,1,0,U,1,0, 1,P,0,0); add(0,1,0,U,1,0, 0,P,0,0);
    add(0,1,0,U,1,0, 0,P,0,0); add(0,1,0,U,1,0, 0,P,0,0); add(0,1,0,U,1,0, 1,P,0,0);
    add(0,1,0,U,1,0, 0,N,0,0);
    // mode 2 (0,+1,0,-1), DC +2^18
    add(1,1,2,U,1,0, 0,Z,0,0); add(0,1,2,U,1,0, 0,Z,0,0); add(0,1,2,U,1,0, 0,Z,0,0);
    add(0,1,2,U,1,0, 1,P,0,0); add(0,1,2,U,1,0, 0,P,0,0); add(0,1,2,U,1,0, 0,Z,0,0);
    add(0,1,2,U,1,0, 0,N,0,0); add(0,1,2,U,1,0, 1,N,0,0); add(0,1,2,U,1,0, 0,N,0,0);
    add(0,1,2,U,1,0, 0,N,0,0);
    // mode 1 (fs/2), DC +2^18
    add(1,1,1,U,1,0, 0,Z,0,0); add(0,1,1,U,1,0, 0,Z,0,0); add(0,1,1,U,1,0, 0,Z,0,0);
    add(0,1,1,U,1,0, 1,N,0,0); add(0,1,1,U,1,0, 0,N,0,0); add(0,1,1,U,1,0, 0,Z,0,0);
    add(0,1,1,U,1,0, 0,P,0,0); add(0,1,1,U,1,0, 1,P,0,0);
    // mode 1, most negative sample: negation must give +2^19 exactly
    add(1,1,1,V,1,0, 0,Z,0,0); add(0,1,1,V,1,0, 0,Z,0,0); add(0,1,1,V,1,0, 0,Z,0,0);
    add(0,1,1,V,1,0, 1,P,0,0); add(0,1,1,V,1,0, 0,P,0,0);
    // underrun, clear, stray valid, clear colliding with a set
    add(1,1,0,U,0,0, 0,Z,1,0); add(0,1,0,U,0,1, 0,Z,0,0); add(0,1,0,U,0,0, 0,Z,0,0);
    add(0,1,0,U,0,0, 1,Z,0,0); add(0,1,0,U,0,0, 0,Z,1,0); add(0,1,0,U,1,0, 0,Z,1,0);
    add(0,1,0,U,0,1, 0,Z,0,0); add(0,1,0,U,0,0, 1,Z,0,0); add(0,1,0,U,0,1, 0,Z,1,0);
    add(0,1,0,U,0,0, 0,Z,1,0); add(0,1,0,U,0,0, 0,Z,1,0);
    // mode 0, DC -2^19: i2 clamps at e10
    add(1,1,0,V,1,0, 0,Z,0,0); add(0,1,0,V,1,0, 0,Z,0,0); add(0,1,0,V,1,0, 0,Z,0,0);
    add(0,1,0,V,1,0, 1,N,0,0); add(0,1,0,V,1,0, 0,N,0,0); add(0,1,0,V,1,0, 0,N,0,0);
    add(0,1,0,V,1,0, 0,N,0,0); add(0,1,0,V,1,0, 1,N,0,0); add(0,1,0,V,1,0, 0,N,0,0);
    add(0,1,0,V,1,0, 0,N,0,0); add(0,1,0,V,1,0, 0,N,0,1); add(0,1,0,V,1,0, 1,N,0,1);

    // reset state
    #12;
    check("rst_pwm", 0, pwm, Z);
    check("rst_ready", 0, in_ready, 1'b0);
    check("rst_underrun", 0, underrun, 1'b0);
    check("rst_overload", 0, overload, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].restart) restart(vecs[i].mode);
      enable    = vecs[i].en;
      lo_mode   = vecs[i].mode;
      in_data   = vecs[i].data[W-1:0];
      in_valid  = vecs[i].valid;
      clr_flags = vecs[i].clr;
      if (vecs[i].restart) begin
        #1;
        check("first_ready", i, in_ready, 1'b1);
      end
      @(posedge clock);
      #1;
      check("ready", i, in_ready, vecs[i].exp_ready);
      check("pwm", i, pwm, vecs[i].exp_pwm);
      check("underrun", i, underrun, vecs[i].exp_under);
      check("overload", i, overload, vecs[i].exp_over);
      $display("step %0d en=%0b mode=%0d data=%0d valid=%0b clr=%0b -> ready=%0b pwm=%b underrun=%0b overload=%0b",
               i, enable, lo_mode, $signed(in_data), in_valid, clr_flags, in_ready, pwm, underrun, overload);
    end

    // async reset between edges while pwm=10 and overload=1
    @(negedge clock);
    #1;
    reset = 1'b0; lo_mode = 2'd0; in_data = '0; in_valid = 1'b1; clr_flags = 1'b0;
    #1;
    check("async_pwm", 0, pwm, Z);
    check("async_ready", 0, in_ready, 1'b0);
    check("async_underrun", 0, underrun, 1'b0);
    check("async_overload", 0, overload, 1'b0);
    $display("async reset: pwm=%b ready=%0b underrun=%0b overload=%0b", pwm, in_ready, underrun, overload);
    #1;
    reset = 1'b1;
    #1;
    check("release_ready", 0, in_ready, 1'b1);
    $display("reset released: ready=%0b", in_ready);

    // zero input, continuously valid, for 1000 cycles
    for (int k = 0; k < 1000; k++) begin
      @(posedge clock);
      #1;
      check("zero_ready", k, in_ready, (k % OSR == OSR - 1) ? 1'b1 : 1'b0);
      check("zero_pwm", k, pwm, Z);
      check("zero_underrun", k, underrun, 1'b0);
      check("zero_overload", k, overload, 1'b0);
    end
    $display("zero-input run: 1000 cycles done, pwm=%b", pwm);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
